// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared CPU control definitions for the block-transfer (LDM/STM) sequencer:
// FSM state encoding, ALU operand-select codes and common widths.
package ldm_stm_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SEL_IR   = 2'b00;
    localparam logic [1:0] SEL_CS   = 2'b01;
    localparam logic [1:0] SEL_UADD = 2'b10;

    localparam int LIST_W = 16;
    localparam int CNT_W  = 5;
    localparam int IDX_W  = 4;
    localparam int OFF_W  = 8;

endpackage

// File: rtl/ldm_stm_sequencer_reg_list_scan.sv
// Register-list scanner: population count and index of the lowest set bit
// of a 16-bit LDM/STM register list (lowest = 0 when the list is empty).
module reg_list_scan
    import ldm_stm_sequencer_pkg::*;
(
    input  logic [LIST_W-1:0] list,
    output logic [CNT_W-1:0]  count,
    output logic [IDX_W-1:0]  lowest
);

    always_comb begin
        count  = '0;
        lowest = '0;
        // Walking downwards lets the last hit be the lowest set bit.
        for (int i = LIST_W - 1; i >= 0; i--) begin
            count = count + CNT_W'(list[i]);
            if (list[i]) begin
                lowest = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list lowest-first,
// issues one word request per register, then optionally writes back Rn.
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LIST_W-1:0]       reg_list,
    input  logic [IDX_W-1:0]        rn,
    input  logic                    u_bit,
    input  logic                    p_bit,
    input  logic                    w_bit,
    input  logic                    l_bit,
    input  logic                    mem_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [IDX_W-1:0]        reg_idx,
    output logic signed [OFF_W-1:0] addr_off,
    output logic                    wb_en,
    output logic signed [OFF_W-1:0] wb_off,
    output logic [1:0]              alu_op_mux,
    output logic                    alu_u
);

    state_t state, state_nxt;

    logic [LIST_W-1:0]       list_q;
    logic [LIST_W-1:0]       pending_q;
    logic [IDX_W-1:0]        rn_q;
    logic                    u_q, p_q, w_q, l_q;
    logic [CNT_W-1:0]        n_q;
    logic signed [OFF_W-1:0] off_q;

    logic [CNT_W-1:0] scan_count;
    logic [IDX_W-1:0] scan_lowest;
    logic             word_done;
    logic             last_word;
    logic             wb_allowed;

    // 4*n as a non-negative signed byte count; n <= 16 keeps it within +64.
    function automatic logic signed [OFF_W-1:0] span_bytes(input logic [CNT_W-1:0] n);
        return signed'({1'b0, n, 2'b00});
    endfunction

    function automatic logic signed [OFF_W-1:0] lowest_offset(
        input logic             p,
        input logic             u,
        input logic [CNT_W-1:0] n
    );
        logic signed [OFF_W-1:0] span;
        span = span_bytes(n);
        case ({p, u})
            2'b01:   return 8'sd0;         // IA
            2'b11:   return 8'sd4;         // IB
            2'b00:   return 8'sd4 - span;  // DA
            default: return -span;         // DB
        endcase
    endfunction

    function automatic logic signed [OFF_W-1:0] writeback_offset(
        input logic             u,
        input logic [CNT_W-1:0] n
    );
        return u ? span_bytes(n) : -span_bytes(n);
    endfunction

    // The pending list equals the latched list in SETUP, so one scanner
    // serves both the word count and the per-word register selection.
    reg_list_scan u_scan (
        .list   (pending_q),
        .count  (scan_count),
        .lowest (scan_lowest)
    );

    assign word_done  = (state == ST_XFER) && mem_ready;
    assign last_word  = word_done && (scan_count == CNT_W'(1));
    // A load that includes the base register keeps the loaded value.
    assign wb_allowed = w_q && !(l_q && list_q[rn_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = (scan_count == '0) ? ST_DONE : ST_XFER;
            ST_XFER:  if (last_word) state_nxt = wb_allowed ? ST_WB : ST_DONE;
            ST_WB:    state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            list_q    <= '0;
            pending_q <= '0;
            rn_q      <= '0;
            u_q       <= 1'b0;
            p_q       <= 1'b0;
            w_q       <= 1'b0;
            l_q       <= 1'b0;
            n_q       <= '0;
            off_q     <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                list_q    <= reg_list;
                pending_q <= reg_list;
                rn_q      <= rn;
                u_q       <= u_bit;
                p_q       <= p_bit;
                w_q       <= w_bit;
                l_q       <= l_bit;
            end
            if (state == ST_SETUP) begin
                n_q   <= scan_count;
                off_q <= lowest_offset(p_q, u_q, scan_count);
            end
            // x & (x-1) drops the lowest set bit: the register just moved.
            if (word_done) begin
                pending_q <= pending_q & (pending_q - LIST_W'(1));
                off_q     <= off_q + 8'sd4;
            end
        end
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_idx    = '0;
        addr_off   = '0;
        wb_en      = 1'b0;
        wb_off     = '0;
        alu_op_mux = SEL_IR;
        alu_u      = 1'b0;
        case (state)
            ST_XFER: begin
                mem_req  = 1'b1;
                mem_we   = ~l_q;
                reg_idx  = scan_lowest;
                addr_off = off_q;
            end
            ST_WB: begin
                wb_en      = 1'b1;
                wb_off     = writeback_offset(u_q, n_q);
                alu_op_mux = SEL_UADD;
                alu_u      = u_q;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
